// File: rtl/exp_request_arbiter_if.sv
// Bundle of requester, datapath and consumer signals around the exponential-unit arbiter.
// The slave modport is the arbiter side; master is the requesters/datapath/consumer side.
interface exp_request_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req1_data;
  logic              req0_ready;
  logic              req1_ready;
  logic              exp_start;
  logic [DATA_W-1:0] exp_operand;
  logic [DATA_W-1:0] exp_result;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_id;
  logic              res_ready;
  logic              busy;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, exp_result, res_ready,
    output req0_ready, req1_ready, exp_start, exp_operand, res_valid, res_data, res_id, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, exp_result, res_ready,
    input  req0_ready, req1_ready, exp_start, exp_operand, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/exp_request_arbiter.sv
// Two-requester arbiter in front of the non-pipelined exponential datapath.
// Round-robin by default; define EXP_ARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module exp_request_arbiter #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 12
) (
  input  logic                 CLK,
  input  logic                 rst,
  exp_request_arbiter_if.slave bus,
  output logic [1:0]           o_dbg_state
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_prio;
  logic              r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_operand;
  logic [DATA_W-1:0] r_res;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Ready depends only on state, prio and the valids (never on data) and is low during reset.
  // The result side follows the same rule with res_valid/res_ready.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_gnt0 = !r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = bus.req0_valid;
        w_gnt1 = bus.req1_valid;
      end
    end
  end

  assign w_xfer = w_gnt0 | w_gnt1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == CNT_ONE) w_next = S_RESP;
      S_RESP:  if (bus.res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_prio    <= 1'b0;
      r_id      <= 1'b0;
      r_cnt     <= '0;
      r_operand <= '0;
      r_res     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_operand <= w_gnt1 ? bus.req1_data : bus.req0_data;
            r_id      <= w_gnt1;
`ifdef EXP_ARB_FIXED_PRIO_EN
            r_prio    <= 1'b0;
`else
            r_prio    <= ~w_gnt1;
`endif
          end
        end
        S_ISSUE: r_cnt <= LAT_C;
        S_WAIT: begin
          // Counter parks at 1 once the result is captured; it never wraps.
          if (r_cnt == CNT_ONE) r_res <= bus.exp_result;
          else                  r_cnt <= r_cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready  = w_gnt0;
  assign bus.req1_ready  = w_gnt1;
  assign bus.exp_start   = (r_state == S_ISSUE);
  assign bus.exp_operand = r_operand;
  assign bus.res_valid   = (r_state == S_RESP);
  assign bus.res_data    = r_res;
  assign bus.res_id      = r_id;
  assign bus.busy        = (r_state != S_IDLE);
  assign o_dbg_state     = r_state;

endmodule
